chunked_adder_seq: RTL and testbench

//  Multi-cycle, parametrised-width adder with x86-style status flags (SF/CF/OF/PF/ZF).

---
 rtl/chunked_adder_seq_if.sv | 39 +++
 rtl/chunked_adder_seq.sv | 132 +++++++++++++
 tb/tb_chunked_adder_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_adder_seq_if.sv
// Handshake and operand/result bundle for chunked_adder_seq.
// Optional macro ADDER_SUB_EN adds the subtract-select signal.
interface chunked_adder_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             SF;
    logic             CF;
    logic             OF;
    logic             PF;
    logic             ZF;

    // Requester side (ALU control FSM / testbench)
    modport master (
        output start, A, B, C0,
`ifdef ADDER_SUB_EN
        output sub,
`endif
        input  ready, done, sum, SF, CF, OF, PF, ZF
    );

    // Adder side
    modport slave (
        input  start, A, B, C0,
`ifdef ADDER_SUB_EN
        input  sub,
`endif
        output ready, done, sum, SF, CF, OF, PF, ZF
    );
endinterface

// File: rtl/chunked_adder_seq.sv
// Multi-cycle chunked adder with x86-style flags (SF/CF/OF/PF/ZF).
// Adds CHUNK bits per clock, LSB chunk first, carrying between chunks
// through a register. WIDTH must be an integer multiple of CHUNK.
// Optional macro ADDER_SUB_EN: enables subtract (A - B - C0) via bus.sub.
//
// state  | meaning
// S_IDLE | ready=1, waiting for start
// S_BUSY | ready=0, one chunk added per clock; done on the last chunk
module chunked_adder_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    chunked_adder_seq_if.slave   bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic             r_ready;
    logic             r_done;
    logic             r_sf;
    logic             r_cf;
    logic             r_of;
    logic             r_pf;
    logic             r_zf;

    logic             w_sub_in;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [CHUNK-1:0] w_res;
    logic             w_cout;
    logic             w_cin_msb;
    logic [WIDTH-1:0] w_final;

`ifdef ADDER_SUB_EN
    assign w_sub_in = bus.sub;
`else
    assign w_sub_in = 1'b0;
`endif

    // Current chunk slice and its add through the registered carry
    assign w_a_chunk   = r_a[int'(r_cnt)*CHUNK +: CHUNK];
    assign w_b_chunk   = r_b[int'(r_cnt)*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_res       = w_chunk_sum[CHUNK-1:0];
    assign w_cout      = w_chunk_sum[CHUNK];
    // Carry into the chunk MSB recovered from the MSB sum bit
    assign w_cin_msb   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_res[CHUNK-1];

    // Full result: earlier chunks from the shadow, final chunk straight from the adder
    always_comb begin
        w_final = r_shadow;
        w_final[WIDTH-1 -: CHUNK] = w_res;
    end

    // Control FSM, operand latch, chunk sequencing and result/flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_sf     <= 1'b0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
            r_pf     <= 1'b0;
            r_zf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Subtract is A + ~B + ~C0; borrow is the inverted carry
                        r_a     <= bus.A;
                        r_b     <= w_sub_in ? ~bus.B : bus.B;
                        r_carry <= bus.C0 ^ w_sub_in;
                        r_sub   <= w_sub_in;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_shadow[int'(r_cnt)*CHUNK +: CHUNK] <= w_res;
                    r_carry <= w_cout;
                    if (r_cnt == CW'(N-1)) begin
                        r_cnt   <= '0;
                        r_sum   <= w_final;
                        r_sf    <= w_final[WIDTH-1];
                        r_cf    <= w_cout ^ r_sub;
                        r_of    <= w_cin_msb ^ w_cout;
                        r_pf    <= ^w_final;
                        r_zf    <= (w_final == '0);
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.SF    = r_sf;
    assign bus.CF    = r_cf;
    assign bus.OF    = r_of;
    assign bus.PF    = r_pf;
    assign bus.ZF    = r_zf;
endmodule

// File: tb/tb_chunked_adder_seq.sv
// Bench for chunked_adder_seq: hand vectors, random ops against an
// arithmetic reference, and multi-cycle handshake/reset sequences.
// Instance 0: WIDTH=64 CHUNK=16; instance 1: WIDTH=64 CHUNK=64.
module tb_chunked_adder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    chunked_adder_seq_if #(.WIDTH(64)) bus0 ();
    chunked_adder_seq_if #(.WIDTH(64)) bus1 ();

    chunked_adder_seq #(.WIDTH(64), .CHUNK(16)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    chunked_adder_seq #(.WIDTH(64), .CHUNK(64)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        c0;
        logic        sb;
        logic [63:0] exp_sum;
        logic [4:0]  exp_flags;   // {SF,CF,OF,PF,ZF}
    } vec_t;

    vec_t vecs[$];

    // Reference: plain wide arithmetic; returns {sum, SF, CF, OF, PF, ZF}
    function automatic logic [68:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic c0, input logic sb);
        logic [64:0] full;
        logic [63:0] s;
        logic        of;
        if (sb) full = {1'b0, a} - {1'b0, b} - 65'(c0);
        else    full = {1'b0, a} + {1'b0, b} + 65'(c0);
        s = full[63:0];
        if (sb) of = (a[63] != b[63]) && (s[63] != a[63]);
        else    of = (a[63] == b[63]) && (s[63] != a[63]);
        return {s, s[63], full[64], of, ^s, (s == 64'd0)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [63:0] a,
                         input logic [63:0] b, input logic c0, input logic sb);
        if (sel == 0) begin
            bus0.start = st; bus0.A = a; bus0.B = b; bus0.C0 = c0;
`ifdef ADDER_SUB_EN
            bus0.sub = sb;
`endif
        end else begin
            bus1.start = st; bus1.A = a; bus1.B = b; bus1.C0 = c0;
`ifdef ADDER_SUB_EN
            bus1.sub = sb;
`endif
        end
        if (sb) begin end
    endtask

    task automatic sample(input int sel, output logic [63:0] s, output logic [4:0] f,
                          output logic d, output logic r);
        if (sel == 0) begin
            s = bus0.sum; f = {bus0.SF, bus0.CF, bus0.OF, bus0.PF, bus0.ZF};
            d = bus0.done; r = bus0.ready;
        end else begin
            s = bus1.sum; f = {bus1.SF, bus1.CF, bus1.OF, bus1.PF, bus1.ZF};
            d = bus1.done; r = bus1.ready;
        end
    endtask

    // One complete operation; called and returns at a negedge with the DUT idle
    task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic c0, input logic sb,
                          output logic [63:0] s, output logic [4:0] f, output int lat);
        logic [63:0] s0;
        logic [4:0]  f0;
        logic        d, r, changed;
        int          guard;
        sample(sel, s0, f0, d, r);
        guard = 0;
        while (!r && guard < 50) begin
            @(negedge clk);
            sample(sel, s0, f0, d, r);
            guard++;
        end
        if (!r) check("ready_wait_timeout", 64'(r), 64'd1);
        drive(sel, 1'b1, a, b, c0, sb);
        @(negedge clk);
        // Operands change while busy; the latched copy must be used
        drive(sel, 1'b0, ~a, ~b, ~c0, sb);
        sample(sel, s0, f0, d, r);
        lat = 0;
        changed = 1'b0;
        d = 1'b0;
        while (!d && lat < 20) begin
            @(negedge clk);
            lat++;
            sample(sel, s, f, d, r);
            if (!d && (s !== s0 || f !== f0)) changed = 1'b1;
        end
        if (!d) check("done_timeout", 64'(d), 64'd1);
        check("no_partial_result", 64'(changed), 64'd0);
    endtask

    initial begin
        logic [63:0] s, rs;
        logic [4:0]  f;
        logic [68:0] m;
        logic        d, r, seen;
        logic        sb;
        logic [63:0] ra, rb;
        logic        rc;
        int          lat;

        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 5'b01001});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 5'b10110});
        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 5'b00010});
        vecs.push_back('{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 5'b00010});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 5'b01101});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11000});
`ifdef ADDER_SUB_EN
        vecs.push_back('{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 5'b11010});
        vecs.push_back('{64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 5'b00010});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00110});
`endif

        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        sample(0, s, f, d, r);
        check("reset_ready", 64'(r), 64'd1);
        check("reset_done", 64'(d), 64'd0);
        check("reset_sum", s, 64'd0);
        check("reset_flags", 64'(f), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Hand vectors on the 4-chunk instance
        foreach (vecs[i]) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sb, s, f, lat);
            check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
            check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].exp_flags));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        // Random ops on both instances against the reference
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) rb = ~ra;
            if (i % 4 == 2) ra = 64'h7FFF_0000_0000_0000 | ra[15:0];
            rc = 1'($urandom);
`ifdef ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            m = model(ra, rb, rc, sb);
            run_op(i % 2, ra, rb, rc, sb, s, f, lat);
            check($sformatf("rand%0d_sum", i), s, m[68:5]);
            check($sformatf("rand%0d_flags", i), 64'(f), 64'(m[4:0]));
            check($sformatf("rand%0d_latency", i), 64'(lat), (i % 2 == 0) ? 64'd4 : 64'd1);
        end

        // Single-chunk instance: registered add in one cycle
        run_op(1, 64'd3, 64'd4, 1'b1, 1'b0, s, f, lat);
        check("n1_sum", s, 64'd8);
        check("n1_flags", 64'(f), 64'b00010);
        check("n1_latency", 64'(lat), 64'd1);

        // start held high 12 cycles: accepts at edges 0, 5, 10
        ra = 64'h0123_4567_89AB_CDEF;
        rb = 64'h1111_2222_3333_4444;
        drive(0, 1'b1, ra, rb, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            sample(0, s, f, d, r);
            check($sformatf("hold_done_c%0d", cyc), 64'(d),
                  (cyc == 4 || cyc == 9 || cyc == 14) ? 64'd1 : 64'd0);
            check($sformatf("hold_ready_c%0d", cyc), 64'(r),
                  (cyc >= 14 || cyc % 5 == 4) ? 64'd1 : 64'd0);
            if (cyc == 11) drive(0, 1'b0, ra, rb, 1'b1, 1'b0);
        end
        m = model(ra, rb, 1'b1, 1'b0);
        check("hold_sum", s, m[68:5]);

        // Reset during the second busy cycle aborts with no done
        run_op(0, 64'd1, 64'd1, 1'b0, 1'b0, s, f, lat);
        check("pre_rst_sum", s, 64'd2);
        drive(0, 1'b1, 64'd10, 64'd20, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 64'd10, 64'd20, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sample(0, s, f, d, r);
        check("abort_ready", 64'(r), 64'd1);
        check("abort_sum", s, 64'd0);
        check("abort_flags", 64'(f), 64'd0);
        check("abort_done", 64'(d), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample(0, rs, f, d, r);
            if (d) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_op(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, s, f, lat);
        check("post_rst_sum", s, 64'h0000_0000_0001_0000);
        check("post_rst_latency", 64'(lat), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
